// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for a small accumulator-less RISC datapath.
// Ports: clk, reset (async, active-low), IR, mem_ready in; datapath enables,
// register selects, memory strobes, mdr_read, control, run, instr_done out.
module control_unit #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] IR,
  input  logic              mem_ready,
  output logic              PCout,
  output logic              PCin,
  output logic              IncPc,
  output logic              MARin,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zlowin,
  output logic              Zlowout,
  output logic              Cout,
  output logic              BAout,
  output logic              Rin,
  output logic              Rout,
  output logic              GRA,
  output logic              GRB,
  output logic              GRC,
  output logic              read,
  output logic              write,
  output logic [1:0]        mdr_read,
  output logic [CTRL_W-1:0] control,
  output logic              run,
  output logic              instr_done
);

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(27);

  localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(5);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d, opc;
  logic             t1w_q, t1w_d;

  logic [OPC_W-1:0] ir_opc;
  logic             unused_ir;
  assign ir_opc    = IR[DATA_W-1 -: OPC_W];
  assign unused_ir = ^IR[DATA_W-OPC_W-1:0];

  // In T3 the IR has just been loaded, so decode it directly while
  // capturing it; later steps use the held copy.
  assign opc   = (state_q == T3) ? ir_opc : opc_q;
  assign opc_d = (state_q == T3) ? ir_opc : opc_q;

  // Set after a stalled T1 cycle so the PC update happens only once.
  assign t1w_d = (state_q == T1) && !mem_ready;

  logic is_ld, is_ldi, is_st, is_mem, is_alu, is_halt;
  assign is_ld   = (opc == OP_LD);
  assign is_ldi  = (opc == OP_LDI);
  assign is_st   = (opc == OP_ST);
  assign is_mem  = is_ld | is_ldi | is_st;
  assign is_alu  = (opc == OP_ADD) | (opc == OP_SUB) |
                   (opc == OP_AND) | (opc == OP_OR);
  assign is_halt = (opc == OP_HALT);

  logic [CTRL_W-1:0] alu_code;
  always_comb begin
    alu_code = ALU_ADD;
    unique case (1'b1)
      (opc == OP_SUB): alu_code = ALU_SUB;
      (opc == OP_AND): alu_code = ALU_AND;
      (opc == OP_OR):  alu_code = ALU_OR;
      default:         alu_code = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= T0;
      opc_q   <= '0;
      t1w_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      t1w_q   <= t1w_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPc      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zlowin     = 1'b0;
    Zlowout    = 1'b0;
    Cout       = 1'b0;
    BAout      = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    GRA        = 1'b0;
    GRB        = 1'b0;
    GRC        = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    mdr_read   = 2'b00;
    control    = '0;
    run        = 1'b1;
    instr_done = 1'b0;
    // Outputs stay quiet while reset is held, even though state reads T0.
    if (reset) begin
      unique case (state_q)
        T0: begin
          PCout   = 1'b1;
          MARin   = 1'b1;
          IncPc   = 1'b1;
          Zlowin  = 1'b1;
          state_d = T1;
        end
        T1: begin
          Zlowout  = !t1w_q;
          PCin     = !t1w_q;
          read     = 1'b1;
          MDRin    = 1'b1;
          mdr_read = 2'b01;
          state_d  = mem_ready ? T2 : T1;
        end
        T2: begin
          MDRout  = 1'b1;
          IRin    = 1'b1;
          state_d = T3;
        end
        T3: begin
          if (is_mem) begin
            GRB     = 1'b1;
            BAout   = 1'b1;
            Yin     = 1'b1;
            state_d = T4;
          end else if (is_alu) begin
            GRB     = 1'b1;
            Rout    = 1'b1;
            Yin     = 1'b1;
            state_d = T4;
          end else if (is_halt) begin
            state_d = HALT;
          end else begin
            instr_done = 1'b1;
            state_d    = T0;
          end
        end
        T4: begin
          Zlowin  = 1'b1;
          state_d = T5;
          if (is_alu) begin
            GRC     = 1'b1;
            Rout    = 1'b1;
            control = alu_code;
          end else begin
            Cout    = 1'b1;
            control = ALU_ADD;
          end
        end
        T5: begin
          Zlowout = 1'b1;
          if (is_ld || is_st) begin
            MARin   = 1'b1;
            state_d = T6;
          end else begin
            GRA        = 1'b1;
            Rin        = 1'b1;
            instr_done = 1'b1;
            state_d    = T0;
          end
        end
        T6: begin
          if (is_ld) begin
            read     = 1'b1;
            MDRin    = 1'b1;
            mdr_read = 2'b01;
            state_d  = mem_ready ? T7 : T6;
          end else if (is_st) begin
            GRA     = 1'b1;
            BAout   = 1'b1;
            MDRin   = 1'b1;
            state_d = T7;
          end else begin
            state_d = T0;
          end
        end
        T7: begin
          if (is_ld) begin
            MDRout     = 1'b1;
            GRA        = 1'b1;
            Rin        = 1'b1;
            instr_done = 1'b1;
            state_d    = T0;
          end else if (is_st) begin
            write      = 1'b1;
            instr_done = mem_ready;
            state_d    = mem_ready ? T0 : T7;
          end else begin
            state_d = T0;
          end
        end
        HALT: begin
          run     = 1'b0;
          state_d = HALT;
        end
        default: state_d = T0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit.
// Packs all outputs into one word and compares it against hand-built words.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic        mem_ready;
  logic PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin;
  logic Zlowin, Zlowout, Cout, BAout, Rin, Rout, GRA, GRB, GRC;
  logic read, write, run, instr_done;
  logic [1:0] mdr_read;
  logic [3:0] control;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPc(IncPc), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zlowout(Zlowout), .Cout(Cout), .BAout(BAout),
    .Rin(Rin), .Rout(Rout), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .read(read), .write(write), .mdr_read(mdr_read),
    .control(control), .run(run), .instr_done(instr_done)
  );

  logic [26:0] obs;
  assign obs = {PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin,
                Zlowin, Zlowout, Cout, BAout, Rin, Rout, GRA, GRB, GRC,
                read, write, mdr_read, control, run, instr_done};

  localparam logic [26:0] PCO  = 27'd1 << 26;
  localparam logic [26:0] PCI  = 27'd1 << 25;
  localparam logic [26:0] INC  = 27'd1 << 24;
  localparam logic [26:0] MARI = 27'd1 << 23;
  localparam logic [26:0] MDRI = 27'd1 << 22;
  localparam logic [26:0] MDRO = 27'd1 << 21;
  localparam logic [26:0] IRI  = 27'd1 << 20;
  localparam logic [26:0] YIN  = 27'd1 << 19;
  localparam logic [26:0] ZLI  = 27'd1 << 18;
  localparam logic [26:0] ZLO  = 27'd1 << 17;
  localparam logic [26:0] COUT = 27'd1 << 16;
  localparam logic [26:0] BAO  = 27'd1 << 15;
  localparam logic [26:0] RIN  = 27'd1 << 14;
  localparam logic [26:0] ROUT = 27'd1 << 13;
  localparam logic [26:0] GA   = 27'd1 << 12;
  localparam logic [26:0] GB   = 27'd1 << 11;
  localparam logic [26:0] GC   = 27'd1 << 10;
  localparam logic [26:0] RD   = 27'd1 << 9;
  localparam logic [26:0] WR   = 27'd1 << 8;
  localparam logic [26:0] MEM  = 27'd1 << 6;
  localparam logic [26:0] RUN  = 27'd1 << 1;
  localparam logic [26:0] DONE = 27'd1;
  localparam logic [26:0] C_ADD = 27'd2 << 2;
  localparam logic [26:0] C_SUB = 27'd3 << 2;

  localparam logic [26:0] E_T0   = PCO | MARI | INC | ZLI | RUN;
  localparam logic [26:0] E_T1F  = ZLO | PCI | RD | MDRI | MEM | RUN;
  localparam logic [26:0] E_T1W  = RD | MDRI | MEM | RUN;
  localparam logic [26:0] E_T2   = MDRO | IRI | RUN;
  localparam logic [26:0] E_T3M  = GB | BAO | YIN | RUN;
  localparam logic [26:0] E_T3A  = GB | ROUT | YIN | RUN;
  localparam logic [26:0] E_T4M  = COUT | ZLI | C_ADD | RUN;
  localparam logic [26:0] E_T4S  = GC | ROUT | ZLI | C_SUB | RUN;
  localparam logic [26:0] E_T5W  = ZLO | GA | RIN | DONE | RUN;
  localparam logic [26:0] E_T5LS = ZLO | MARI | RUN;
  localparam logic [26:0] E_T6L  = RD | MDRI | MEM | RUN;
  localparam logic [26:0] E_T6S  = GA | BAO | MDRI | RUN;
  localparam logic [26:0] E_T7L  = MDRO | GA | RIN | DONE | RUN;
  localparam logic [26:0] E_T7S  = WR | RUN;
  localparam logic [26:0] E_T7SD = WR | DONE | RUN;
  localparam logic [26:0] E_RST  = RUN;
  localparam logic [26:0] E_HALT = 27'd0;

  task automatic chk(input string tag, input logic [26:0] got,
                     input logic [26:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One clock: drive mem_ready on the falling edge, then sample.
  task automatic cyc(input logic mr, input string tag,
                     input logic [26:0] exp);
    @(negedge clk);
    mem_ready = mr;
    #1;
    chk(tag, obs, exp);
  endtask

  initial begin
    reset     = 1'b0;
    IR        = 32'h0800_0012;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset", obs, E_RST);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("ldi_t0", obs, E_T0);
    cyc(1, "ldi_t1", E_T1F);
    cyc(1, "ldi_t2", E_T2);
    cyc(1, "ldi_t3", E_T3M);
    cyc(1, "ldi_t4", E_T4M);
    cyc(1, "ldi_t5", E_T5W);
    cyc(1, "ldi_end", E_T0);

    IR = 32'h1000_0013;
    cyc(1, "st_t1", E_T1F);
    cyc(1, "st_t2", E_T2);
    cyc(1, "st_t3", E_T3M);
    cyc(1, "st_t4", E_T4M);
    cyc(1, "st_t5", E_T5LS);
    cyc(1, "st_t6", E_T6S);
    cyc(0, "st_t7a", E_T7S);
    cyc(0, "st_t7b", E_T7S);
    cyc(0, "st_t7c", E_T7S);
    cyc(1, "st_t7d", E_T7SD);
    cyc(1, "st_end", E_T0);

    IR = 32'h0000_0014;
    cyc(0, "ld_t1a", E_T1F);
    cyc(0, "ld_t1b", E_T1W);
    cyc(1, "ld_t1c", E_T1W);
    cyc(1, "ld_t2", E_T2);
    cyc(1, "ld_t3", E_T3M);
    cyc(1, "ld_t4", E_T4M);
    cyc(1, "ld_t5", E_T5LS);
    cyc(1, "ld_t6", E_T6L);
    cyc(1, "ld_t7", E_T7L);
    cyc(1, "ld_end", E_T0);

    IR = 32'h2000_0000;
    cyc(1, "sub_t1", E_T1F);
    cyc(1, "sub_t2", E_T2);
    cyc(1, "sub_t3", E_T3A);
    cyc(1, "sub_t4", E_T4S);
    cyc(1, "sub_t5", E_T5W);
    cyc(1, "sub_end", E_T0);

    IR = 32'h3800_0000;
    cyc(1, "nop_t1", E_T1F);
    cyc(1, "nop_t2", E_T2);
    cyc(1, "nop_t3", DONE | RUN);
    cyc(1, "nop_end", E_T0);

    IR = 32'h0000_0014;
    cyc(1, "ldr_t1", E_T1F);
    cyc(1, "ldr_t2", E_T2);
    cyc(1, "ldr_t3", E_T3M);
    cyc(1, "ldr_t4", E_T4M);
    cyc(1, "ldr_t5", E_T5LS);
    cyc(0, "ldr_t6a", E_T6L);
    cyc(0, "ldr_t6b", E_T6L);
    #2 reset = 1'b0;
    #1 chk("ldr_rst", obs, E_RST);
    @(negedge clk);
    #1 chk("ldr_rst_hold", obs, E_RST);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1 chk("ldr_t0", obs, E_T0);

    IR = 32'hD800_0000;
    cyc(1, "hlt_t1", E_T1F);
    cyc(1, "hlt_t2", E_T2);
    cyc(1, "hlt_t3", E_RST);
    for (int i = 0; i < 10; i++) cyc(1, "halt", E_HALT);
    reset = 1'b0;
    #1 chk("hlt_rst", obs, E_RST);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("hlt_t0", obs, E_T0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
